bram_wr_sched: RTL and testbench
================================

// Module: bram_wr_sched
// PURPOSE
//  Schedules result writes from two capture stages into one single-port BRAM (port A).
//  Each requester issues single-cycle valid pulses with data; the block buffers one
//  sample per requester, arbitrates round-robin and generates ena/wea/addra/dina.
//  Requester 0 fills addresses [0, LEN-1]; requester 1 fills [LEN, 2*LEN-1].
//  Sits between the capture stages and the result BRAM; a frame starts on start.
// PARAMETERS
//  int_bits   20   data width
//  addr_bits  10   BRAM address width; 2*LEN <= 2**addr_bits
//  LEN        512  samples per requester per frame
// PORTS
//  clk        in   1          clock, rising edge
//  reset_n    in   1          asynchronous, active-low reset
//  start      in   1          1-cycle pulse: clear counters/flags, begin frame
//  in0_vld    in   1          requester 0 sample valid (1-cycle pulse)
//  in0_data   in   int_bits   requester 0 sample
//  in1_vld    in   1          requester 1 sample valid
//  in1_data   in   int_bits   requester 1 sample
//  ena        out  1          BRAM enable (equals wea)
//  wea        out  1          BRAM write enable
//  addra      out  addr_bits  BRAM write address
//  dina       out  int_bits   BRAM write data
//  busy       out  1          high in RUN
//  done       out  1          high in DONE (level) until next start
//  ovf_err    out  1          sticky: a sample was dropped on a full buffer
// BEHAVIOUR
//  - Reset (async, reset_n=0): all outputs 0, state IDLE, counters 0, buffers empty,
//    rr pointer = 0. Reset mid-frame abandons the frame; no partial writes follow.
//  - States: IDLE -start-> RUN; RUN -(cnt0==LEN && cnt1==LEN && buffers empty)-> DONE;
//    DONE -start-> RUN; start in RUN restarts the frame (counters, buffers, ovf_err clear).
//  - In IDLE/DONE, in*_vld is ignored.
//  - Capture: in RUN, inN_vld at edge t loads bufN (pendN=1) if accepted count
//    accN < LEN; samples beyond LEN per requester are ignored without error.
//  - Overflow: inN_vld while pendN=1 and bufN is not granted in that cycle -> new
//    sample dropped, ovf_err set (sticky until start/reset). Valid arriving in the
//    cycle its buffer is granted reloads the buffer; no overflow.
//  - Arbitration (comb from pend): one grant per cycle. Only one pending -> grant it.
//    Both pending -> grant requester rr; after any grant rr = other requester.
//  - Write: granted buffer is registered to outputs at the next edge: wea=ena=1 for
//    exactly one cycle, addra = N*LEN + cntN, dina = bufN; cntN increments.
//    Latency: valid pulse in cycle t -> wea high in cycle t+2 if uncontended.
//  - wea=0 cycles hold addra/dina at last value.
//  - Throughput: 1 write/cycle; both requesters pulsing every 2nd cycle never overflow.
//  - done asserts the cycle after the last write; busy deasserts same cycle.
// TESTING (LEN=4, addr_bits=4, int_bits=20)
//  1 reset_n=0 mid-frame with pend0=1 -> all outputs 0 immediately; no wea after release.
//  2 start, in0 pulses 0x11,0x22,0x33,0x44 every 3 cycles -> wea at addra 0..3 with
//    those data, each 2 cycles after its pulse; requester 1 idle -> done stays 0.
//  3 start, in0/in1 pulse together 4 times every 2 cycles (0xA0+i / 0xB0+i) -> writes
//    alternate addr 0,4,1,5,2,6,3,7; done=1 after write to 7; ovf_err=0.
//  4 start, in0 pulses on 2 consecutive cycles while in1 also pending and rr=1 ->
//    second in0 sample dropped, ovf_err=1, stays 1 until next start.
//  5 frame complete, then 5th in0 pulse and extra in1 pulses -> no wea, ovf_err=0, done=1.
//  6 start asserted in RUN after 2 writes -> counters reset; next in1 sample written at addr 4.

Source files
------------

// File: rtl/bram_wr_sched.sv
// Purpose: round-robin scheduler merging two single-sample capture streams into one BRAM write port.
// Latency: a valid pulse in cycle t produces wea in cycle t+2 when uncontended.
// Backpressure: none upstream; a sample arriving on a still-occupied, ungranted buffer is dropped and ovf_err is set.
module bram_wr_sched #(
    parameter int int_bits  = 20,
    parameter int addr_bits = 10,
    parameter int LEN       = 512
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 in0_vld,
    input  logic [int_bits-1:0]  in0_data,
    input  logic                 in1_vld,
    input  logic [int_bits-1:0]  in1_data,
    output logic                 ena,
    output logic                 wea,
    output logic [addr_bits-1:0] addra,
    output logic [int_bits-1:0]  dina,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf_err
);

    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0]        LEN_C = CW'(LEN);
    localparam logic [addr_bits-1:0] BASE1 = addr_bits'(LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [int_bits-1:0] buf_q  [2];
    logic                pend_q [2];
    logic [CW-1:0]       acc_q  [2];   // samples accepted into the buffer this frame
    logic [CW-1:0]       cnt_q  [2];   // samples written to BRAM this frame
    logic                rr_q;
    logic                ovf_q;

    logic                vld    [2];
    logic [int_bits-1:0] data   [2];
    logic                gnt    [2];
    logic                run_act;

    assign vld[0]  = in0_vld;
    assign vld[1]  = in1_vld;
    assign data[0] = in0_data;
    assign data[1] = in1_data;

    // A start pulse flushes the frame, so nothing is granted in that cycle.
    assign run_act = (state_q == RUN) && !start;

    // Single grant per cycle; rr only breaks ties when both buffers hold a sample.
    always_comb begin
        gnt[0] = run_act && pend_q[0] && (!pend_q[1] || !rr_q);
        gnt[1] = run_act && pend_q[1] && (!pend_q[0] ||  rr_q);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; the frame ends once every sample is written out.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (start) begin
                    state_d = RUN;
                end else if ((cnt_q[0] == LEN_C) && (cnt_q[1] == LEN_C) &&
                             !pend_q[0] && !pend_q[1]) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture buffers: a valid reloads the buffer when it is empty or being drained this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_q[i]  <= '0;
                pend_q[i] <= 1'b0;
                acc_q[i]  <= '0;
            end
            ovf_q <= 1'b0;
        end else if (start) begin
            for (int i = 0; i < 2; i++) begin
                pend_q[i] <= 1'b0;
                acc_q[i]  <= '0;
            end
            ovf_q <= 1'b0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < 2; i++) begin
                if (vld[i] && (acc_q[i] < LEN_C)) begin
                    if (pend_q[i] && !gnt[i]) begin
                        ovf_q <= 1'b1;
                    end else begin
                        buf_q[i]  <= data[i];
                        pend_q[i] <= 1'b1;
                        acc_q[i]  <= acc_q[i] + CW'(1);
                    end
                end else if (gnt[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // BRAM write port: register the granted sample; address/data hold while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wea      <= 1'b0;
            addra    <= '0;
            dina     <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            rr_q     <= 1'b0;
        end else if (start) begin
            wea      <= 1'b0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            rr_q     <= 1'b0;
        end else begin
            wea <= gnt[0] | gnt[1];
            if (gnt[0]) begin
                addra    <= addr_bits'(cnt_q[0]);
                dina     <= buf_q[0];
                cnt_q[0] <= cnt_q[0] + CW'(1);
                rr_q     <= 1'b1;
            end else if (gnt[1]) begin
                addra    <= BASE1 + addr_bits'(cnt_q[1]);
                dina     <= buf_q[1];
                cnt_q[1] <= cnt_q[1] + CW'(1);
                rr_q     <= 1'b0;
            end
        end
    end

    assign ena     = wea;
    assign ovf_err = ovf_q;

endmodule

// File: tb/tb_bram_wr_sched.sv
// Purpose: randomized and directed bench for bram_wr_sched against a frame-level reference model.
// Latency: outputs compared 1 ns after every rising edge.
// Backpressure: n/a; drives single-cycle valid pulses only.
module tb_bram_wr_sched;

    localparam int IB = 20;
    localparam int AB = 4;
    localparam int L  = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          in0_vld;
    logic [IB-1:0] in0_data;
    logic          in1_vld;
    logic [IB-1:0] in1_data;
    logic          ena;
    logic          wea;
    logic [AB-1:0] addra;
    logic [IB-1:0] dina;
    logic          busy;
    logic          done;
    logic          ovf_err;

    always #5 clk = ~clk;

    bram_wr_sched #(.int_bits(IB), .addr_bits(AB), .LEN(L)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .in0_vld  (in0_vld),
        .in0_data (in0_data),
        .in1_vld  (in1_vld),
        .in1_data (in1_data),
        .ena      (ena),
        .wea      (wea),
        .addra    (addra),
        .dina     (dina),
        .busy     (busy),
        .done     (done),
        .ovf_err  (ovf_err)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Reference model: frame phase (0 idle, 1 running, 2 finished), one slot per requester.
    int          m_phase;
    bit          m_full [2];
    int unsigned m_sdat [2];
    int          m_acc  [2];
    int          m_wr   [2];
    int          m_rr;
    bit          m_wea;
    bit          m_ovf;
    int unsigned m_addr;
    int unsigned m_dat;

    // Writes observed on the BRAM port.
    int unsigned seen_addr [$];
    int unsigned seen_dat  [$];
    int          seen_cyc  [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_rr    = 0;
        m_wea   = 0;
        m_ovf   = 0;
        m_addr  = 0;
        m_dat   = 0;
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0;
            m_sdat[i] = 0;
            m_acc[i]  = 0;
            m_wr[i]   = 0;
        end
    endtask

    // Advance the model across one clock edge given the inputs presented before it.
    task automatic model_step(input bit st, input bit v0, input int unsigned d0,
                              input bit v1, input int unsigned d1);
        bit          v [2];
        int unsigned d [2];
        int          served;
        bit          finished;
        v[0] = v0; v[1] = v1; d[0] = d0; d[1] = d1;
        if (st) begin
            m_phase = 1;
            m_rr    = 0;
            m_wea   = 0;
            m_ovf   = 0;
            for (int i = 0; i < 2; i++) begin
                m_full[i] = 0;
                m_acc[i]  = 0;
                m_wr[i]   = 0;
            end
            return;
        end
        m_wea = 0;
        if (m_phase != 1) return;
        finished = (m_wr[0] == L) && (m_wr[1] == L) && !m_full[0] && !m_full[1];
        served = -1;
        if (m_full[0] && m_full[1]) served = m_rr;
        else if (m_full[0])         served = 0;
        else if (m_full[1])         served = 1;
        if (served >= 0) begin
            m_wea  = 1;
            m_addr = served * L + m_wr[served];
            m_dat  = m_sdat[served];
            m_wr[served]++;
            m_rr   = 1 - served;
        end
        for (int i = 0; i < 2; i++) begin
            if (v[i] && m_acc[i] < L) begin
                if (m_full[i] && served != i) begin
                    m_ovf = 1;
                end else begin
                    m_sdat[i] = d[i];
                    m_full[i] = 1;
                    m_acc[i]++;
                end
            end else if (served == i) begin
                m_full[i] = 0;
            end
        end
        if (finished) m_phase = 2;
    endtask

    task automatic check_outputs();
        chk("wea",   {31'd0, wea},     {31'd0, m_wea});
        chk("ena",   {31'd0, ena},     {31'd0, m_wea});
        chk("addra", {28'd0, addra},   m_addr);
        chk("dina",  {12'd0, dina},    m_dat);
        chk("busy",  {31'd0, busy},    {31'd0, (m_phase == 1)});
        chk("done",  {31'd0, done},    {31'd0, (m_phase == 2)});
        chk("ovf",   {31'd0, ovf_err}, {31'd0, m_ovf});
    endtask

    // One clock: drive inputs, step the model, compare after the edge.
    task automatic cycle(input bit st, input bit v0, input logic [IB-1:0] d0,
                         input bit v1, input logic [IB-1:0] d1);
        start    = st;
        in0_vld  = v0;
        in0_data = d0;
        in1_vld  = v1;
        in1_data = d1;
        model_step(st, v0, 32'(d0), v1, 32'(d1));
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (wea === 1'b1) begin
            seen_addr.push_back(32'(addra));
            seen_dat.push_back(32'(dina));
            seen_cyc.push_back(cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, '0, 0, '0);
    endtask

    task automatic clear_seen();
        seen_addr.delete();
        seen_dat.delete();
        seen_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pulse_cyc [4];
        logic [IB-1:0] v2 [4];
        int unsigned exp3_addr [8];
        int          p0, p1, pst;

        v2[0] = 20'h11; v2[1] = 20'h22; v2[2] = 20'h33; v2[3] = 20'h44;
        exp3_addr[0] = 0; exp3_addr[1] = 4; exp3_addr[2] = 1; exp3_addr[3] = 5;
        exp3_addr[4] = 2; exp3_addr[5] = 6; exp3_addr[6] = 3; exp3_addr[7] = 7;

        reset_n = 1'b0; start = 0; in0_vld = 0; in1_vld = 0; in0_data = '0; in1_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        reset_n = 1'b1;
        idle(2);

        // Reset in the middle of a frame with requester 0's buffer occupied.
        cycle(1, 0, '0, 0, '0);
        cycle(0, 1, 20'h55, 0, '0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_wea",  {31'd0, wea},  32'd0);
        chk("rst_addr", {28'd0, addra}, 32'd0);
        chk("rst_dina", {12'd0, dina}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_seen();
        idle(5);
        chk("rst_nowr", seen_addr.size(), 0);

        // Requester 0 alone, pulses every third cycle.
        cycle(1, 0, '0, 0, '0);
        clear_seen();
        for (int i = 0; i < 4; i++) begin
            pulse_cyc[i] = cyc;
            cycle(0, 1, v2[i], 0, '0);
            idle(2);
        end
        idle(4);
        chk("t2_nwr", seen_addr.size(), 4);
        for (int i = 0; i < 4 && i < seen_addr.size(); i++) begin
            chk("t2_addr", seen_addr[i], i);
            chk("t2_dat",  seen_dat[i], 32'(v2[i]));
            chk("t2_lat",  seen_cyc[i] - pulse_cyc[i], 2);
        end
        chk("t2_done", {31'd0, done}, 32'd0);

        // Both requesters every second cycle: strict alternation, frame completes.
        cycle(1, 0, '0, 0, '0);
        clear_seen();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, IB'(32'hA0 + i), 1, IB'(32'hB0 + i));
            idle(1);
        end
        idle(4);
        chk("t3_nwr", seen_addr.size(), 8);
        for (int i = 0; i < 8 && i < seen_addr.size(); i++) begin
            chk("t3_addr", seen_addr[i], exp3_addr[i]);
            chk("t3_dat",  seen_dat[i], (i % 2 == 0) ? 32'hA0 + i / 2 : 32'hB0 + i / 2);
        end
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_ovf",  {31'd0, ovf_err}, 32'd0);

        // Extra pulses after the frame has completed are ignored.
        clear_seen();
        for (int i = 0; i < 3; i++) cycle(0, 1, 20'h99, 1, 20'h98);
        idle(2);
        chk("t5_nwr",  seen_addr.size(), 0);
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_ovf",  {31'd0, ovf_err}, 32'd0);

        // Back-to-back requester 0 samples while requester 1 holds the tie-break.
        cycle(1, 0, '0, 0, '0);
        cycle(0, 1, 20'h1, 1, 20'h2);
        cycle(0, 1, 20'h3, 0, '0);
        cycle(0, 1, 20'h4, 0, '0);
        chk("t4_ovf_set", {31'd0, ovf_err}, 32'd1);
        idle(5);
        chk("t4_ovf_sticky", {31'd0, ovf_err}, 32'd1);
        cycle(1, 0, '0, 0, '0);
        chk("t4_ovf_clr", {31'd0, ovf_err}, 32'd0);

        // Restart mid-frame after two writes.
        cycle(0, 1, 20'h61, 0, '0);
        cycle(0, 1, 20'h62, 0, '0);
        idle(3);
        cycle(1, 0, '0, 0, '0);
        clear_seen();
        cycle(0, 0, '0, 1, 20'h71);
        idle(3);
        chk("t6_nwr", seen_addr.size(), 1);
        if (seen_addr.size() > 0) begin
            chk("t6_addr", seen_addr[0], 4);
            chk("t6_dat",  seen_dat[0], 32'h71);
        end

        // Randomized frames with varying pulse densities and occasional restarts.
        p0 = 50; p1 = 50; pst = 0;
        cycle(1, 0, '0, 0, '0);
        for (int k = 0; k < 3000; k++) begin
            bit st, a, b;
            if (done === 1'b1 && $urandom_range(0, 3) == 0) begin
                st = 1;
                p0 = $urandom_range(10, 90);
                p1 = $urandom_range(10, 90);
            end else begin
                st = ($urandom_range(0, 299) == 0);
            end
            a = ($urandom_range(0, 99) < p0);
            b = ($urandom_range(0, 99) < p1);
            if (st) pst++;
            cycle(st, a, IB'($urandom), b, IB'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
